memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 145 ++++++++++++++
 tb/tb_memory_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-requester (core / debug) arbiter in front of a single-port synchronous memory.
// Round-robin on ties, debug bus lock with a bounded core-starvation override.
module memory_arbiter #(
    parameter int   MAX_LOCK    = 16,
    parameter logic RESET_OWNER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic        core_wr_ena,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wr_data,
    output logic        core_gnt,
    output logic        core_rd_valid,
    output logic [31:0] core_rd_data,

    input  logic        dbg_req,
    input  logic        dbg_wr_ena,
    input  logic        dbg_lock,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wr_data,
    output logic        dbg_gnt,
    output logic        dbg_rd_valid,
    output logic [31:0] dbg_rd_data,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    input  logic [31:0] mem_rd_data
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CORE,
        S_DBG,
        S_DBG_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic            last_owner_q, last_owner_d;   // 1 = debug granted last
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            core_rd_valid_q, core_rd_valid_d;
    logic            dbg_rd_valid_q, dbg_rd_valid_d;

    logic            locked;
    logic            lock_override;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            last_owner_q    <= RESET_OWNER;
            lock_cnt_q      <= '0;
            core_rd_valid_q <= 1'b0;
            dbg_rd_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_owner_q    <= last_owner_d;
            lock_cnt_q      <= lock_cnt_d;
            core_rd_valid_q <= core_rd_valid_d;
            dbg_rd_valid_q  <= dbg_rd_valid_d;
        end
    end

    // Lock only holds while dbg_lock stays high; dropping it falls straight back
    // to normal arbitration in the same cycle.
    assign locked        = (state_q == S_DBG_LOCK) && dbg_lock;
    assign lock_override = locked && core_req && (lock_cnt_q == CW'(MAX_LOCK));

    always_comb begin
        core_gnt     = 1'b0;
        dbg_gnt      = 1'b0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        lock_cnt_d   = '0;

        if (!rst) begin
            if (locked) begin
                if (lock_override) begin
                    core_gnt = 1'b1;
                end else begin
                    dbg_gnt = dbg_req;
                end
            end else if (core_req && dbg_req) begin
                if (last_owner_q) begin
                    core_gnt = 1'b1;
                end else begin
                    dbg_gnt = 1'b1;
                end
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end

        if (locked) begin
            // The override grant does not break the lock, it only restarts the count.
            state_d = S_DBG_LOCK;
            if (core_req && !lock_override) begin
                lock_cnt_d = lock_cnt_q + CW'(1);
            end
        end else if (dbg_gnt && dbg_lock) begin
            state_d = S_DBG_LOCK;
        end else if (core_gnt) begin
            state_d = S_CORE;
        end else if (dbg_gnt) begin
            state_d = S_DBG;
        end else begin
            state_d = S_IDLE;
        end

        if (core_gnt) begin
            last_owner_d = 1'b0;
        end else if (dbg_gnt) begin
            last_owner_d = 1'b1;
        end

        core_rd_valid_d = core_gnt && !core_wr_ena;
        dbg_rd_valid_d  = dbg_gnt && !dbg_wr_ena;
    end

    always_comb begin
        mem_addr    = core_addr;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        if (core_gnt) begin
            mem_addr    = core_addr;
            mem_wr_data = core_wr_data;
            mem_wr_ena  = core_wr_ena;
        end else if (dbg_gnt) begin
            mem_addr    = dbg_addr;
            mem_wr_data = dbg_wr_data;
            mem_wr_ena  = dbg_wr_ena;
        end
    end

    // A reset arriving while a read is in flight suppresses its valid pulse.
    assign core_rd_valid = core_rd_valid_q && !rst;
    assign dbg_rd_valid  = dbg_rd_valid_q && !rst;
    assign core_rd_data  = mem_rd_data;
    assign dbg_rd_data   = mem_rd_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and constrained-random checks of memory_arbiter against a small
// synchronous memory model; expected values are hand-derived per scenario.
module tb_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        core_req, core_wr_ena;
    logic [31:0] core_addr, core_wr_data;
    logic        core_gnt, core_rd_valid;
    logic [31:0] core_rd_data;
    logic        dbg_req, dbg_wr_ena, dbg_lock;
    logic [31:0] dbg_addr, dbg_wr_data;
    logic        dbg_gnt, dbg_rd_valid;
    logic [31:0] dbg_rd_data;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_ena;

    logic [31:0] mem [0:255];

    int n_cmp;
    int n_mis;

    logic exp_c, exp_d;
    logic prev_cg, prev_dg, pend_crd, pend_drd;
    logic [31:0] exp_wr;

    memory_arbiter #(
        .MAX_LOCK    (4),
        .RESET_OWNER (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_req      (core_req),
        .core_wr_ena   (core_wr_ena),
        .core_addr     (core_addr),
        .core_wr_data  (core_wr_data),
        .core_gnt      (core_gnt),
        .core_rd_valid (core_rd_valid),
        .core_rd_data  (core_rd_data),
        .dbg_req       (dbg_req),
        .dbg_wr_ena    (dbg_wr_ena),
        .dbg_lock      (dbg_lock),
        .dbg_addr      (dbg_addr),
        .dbg_wr_data   (dbg_wr_data),
        .dbg_gnt       (dbg_gnt),
        .dbg_rd_valid  (dbg_rd_valid),
        .dbg_rd_data   (dbg_rd_data),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ena    (mem_wr_ena),
        .mem_rd_data   (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory preloads word i with 0xA000_0000 + i; read data lands one cycle after the address.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem_rd_data <= '0;
        end else begin
            if (mem_wr_ena) mem[mem_addr[9:2]] <= mem_wr_data;
            mem_rd_data <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1;
        core_req = 1'b1; core_wr_ena = 1'b1; core_addr = 32'h10; core_wr_data = 32'h1234;
        dbg_req = 1'b1; dbg_wr_ena = 1'b1; dbg_lock = 1'b0; dbg_addr = 32'h20; dbg_wr_data = 32'h5678;
        tick();
        tick();
        #1;
        chk("rst_core_gnt", 32'(core_gnt), 0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("rst_wr_ena", 32'(mem_wr_ena), 0);
        chk("rst_core_rv", 32'(core_rd_valid), 0);
        chk("rst_dbg_rv", 32'(dbg_rd_valid), 0);

        // Alternating reads on a permanent tie, core first after reset.
        rst = 1'b0; core_wr_ena = 1'b0; dbg_wr_ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_c = (i % 2 == 0);
            chk("rr_core_gnt", 32'(core_gnt), 32'(exp_c));
            chk("rr_dbg_gnt", 32'(dbg_gnt), 32'(!exp_c));
            chk("rr_mem_addr", mem_addr, exp_c ? 32'h10 : 32'h20);
            tick();
            chk("rr_core_rv", 32'(core_rd_valid), 32'(exp_c));
            chk("rr_dbg_rv", 32'(dbg_rd_valid), 32'(!exp_c));
            if (exp_c) chk("rr_core_data", core_rd_data, 32'hA000_0004);
            else       chk("rr_dbg_data", dbg_rd_data, 32'hA000_0008);
        end

        // Core-only write, then read back.
        dbg_req = 1'b0; core_wr_ena = 1'b1; core_addr = 32'h40; core_wr_data = 32'hDEAD_BEEF;
        #1;
        chk("wr_core_gnt", 32'(core_gnt), 1);
        chk("wr_wr_ena", 32'(mem_wr_ena), 1);
        chk("wr_mem_addr", mem_addr, 32'h40);
        chk("wr_mem_data", mem_wr_data, 32'hDEAD_BEEF);
        tick();
        chk("wr_core_rv", 32'(core_rd_valid), 0);
        core_wr_ena = 1'b0;
        #1;
        chk("rb_core_gnt", 32'(core_gnt), 1);
        chk("rb_wr_ena", 32'(mem_wr_ena), 0);
        tick();
        chk("rb_core_rv", 32'(core_rd_valid), 1);
        chk("rb_core_data", core_rd_data, 32'hDEAD_BEEF);

        // Lock entry: core granted last, so the debug locking request wins the tie.
        core_addr = 32'h10; dbg_req = 1'b1; dbg_lock = 1'b1;
        #1;
        chk("lk_entry_dbg", 32'(dbg_gnt), 1);
        chk("lk_entry_core", 32'(core_gnt), 0);
        tick();
        // With MAX_LOCK=4: four starved cycles, then one core override, repeating.
        for (int k = 0; k < 11; k++) begin
            dbg_req = (k % 2 == 0);
            #1;
            exp_c = (k % 5 == 4);
            exp_d = dbg_req && !exp_c;
            chk("lk_core_gnt", 32'(core_gnt), 32'(exp_c));
            chk("lk_dbg_gnt", 32'(dbg_gnt), 32'(exp_d));
            if (exp_c) chk("lk_mem_addr", mem_addr, 32'h10);
            tick();
        end

        // Release with both requesting: core wins immediately, then round-robin resumes.
        dbg_lock = 1'b0; dbg_req = 1'b1;
        #1;
        chk("rel_core_gnt", 32'(core_gnt), 1);
        chk("rel_dbg_gnt", 32'(dbg_gnt), 0);
        tick();
        chk("rel2_dbg_gnt", 32'(dbg_gnt), 1);
        chk("rel2_core_gnt", 32'(core_gnt), 0);

        // Reset in the cycle after a debug read grant.
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_dbg_rv", 32'(dbg_rd_valid), 0);
        chk("mrst_core_gnt", 32'(core_gnt), 0);
        chk("mrst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("mrst_wr_ena", 32'(mem_wr_ena), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("prst_core_gnt", 32'(core_gnt), 1);
        chk("prst_dbg_gnt", 32'(dbg_gnt), 0);
        chk("prst_dbg_rv", 32'(dbg_rd_valid), 0);
        chk("prst_core_rv", 32'(core_rd_valid), 0);
        tick();

        // Random traffic; a requester keeps its request stable until granted.
        prev_cg = 1'b1; prev_dg = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if (!core_req || prev_cg) begin
                core_req     = ($urandom_range(0, 2) != 0);
                core_wr_ena  = $urandom_range(0, 1) == 1;
                core_addr    = 32'($urandom_range(0, 255)) << 2;
                core_wr_data = $urandom;
            end
            if (!dbg_req || prev_dg) begin
                dbg_req     = ($urandom_range(0, 2) != 0);
                dbg_wr_ena  = $urandom_range(0, 1) == 1;
                dbg_addr    = 32'($urandom_range(0, 255)) << 2;
                dbg_wr_data = $urandom;
            end
            if ($urandom_range(0, 9) == 0) dbg_lock = ~dbg_lock;
            #1;
            chk("rnd_both_gnt", 32'(core_gnt && dbg_gnt), 0);
            chk("rnd_core_noreq", 32'(core_gnt && !core_req), 0);
            chk("rnd_dbg_noreq", 32'(dbg_gnt && !dbg_req), 0);
            exp_wr = core_gnt ? 32'(core_wr_ena) : (dbg_gnt ? 32'(dbg_wr_ena) : 0);
            chk("rnd_wr_ena", 32'(mem_wr_ena), exp_wr);
            prev_cg  = core_gnt;
            prev_dg  = dbg_gnt;
            pend_crd = core_gnt && !core_wr_ena;
            pend_drd = dbg_gnt && !dbg_wr_ena;
            tick();
            chk("rnd_core_rv", 32'(core_rd_valid), 32'(pend_crd));
            chk("rnd_dbg_rv", 32'(dbg_rd_valid), 32'(pend_drd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
